// File: rtl/p2s_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial transmitter.
package p2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAD   = 2'd2
    } p2s_state_e;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_PAD_BITS  = 1;
    localparam int DEF_MSB_FIRST = 1;

    // Counter must hold every slot index of a frame, 0..DATA_W+PAD_BITS-1.
    function automatic int cnt_width(input int data_w, input int pad_bits);
        return $clog2(data_w + pad_bits + 1);
    endfunction

endpackage

// File: rtl/parallel2serial_if.sv
// Word-in / bit-out handshake bundle of the parallel-to-serial transmitter.
interface parallel2serial_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din_parallel;
    logic              din_valid;
    logic              din_ready;
    logic              dout_serial;
    logic              dout_valid;
    logic              dout_last;
    logic              busy;

    modport master (
        output din_parallel, din_valid,
        input  din_ready, dout_serial, dout_valid, dout_last, busy
    );

    modport slave (
        input  din_parallel, din_valid,
        output din_ready, dout_serial, dout_valid, dout_last, busy
    );
endinterface

// File: rtl/p2s_hold_buf.sv
// One-entry holding register; ready is registered so it never depends on din_valid.
module p2s_hold_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              full_nx,
    output logic              ready
);

    logic [DATA_W-1:0] data_r;
    logic              full_r;
    logic              ready_r;
    logic              full_nx_s;

    // Next occupancy; push only happens while empty, so it never meets a pop.
    always_comb begin
        full_nx_s = full_r;
        if (push) begin
            full_nx_s = 1'b1;
        end else if (pop) begin
            full_nx_s = 1'b0;
        end else begin
            full_nx_s = full_r;
        end
    end

    // Data, full flag and registered ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r  <= '0;
            full_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            if (push) begin
                data_r <= din;
            end
            full_r  <= full_nx_s;
            ready_r <= !full_nx_s;
        end
    end

    assign dout    = data_r;
    assign full    = full_r;
    assign full_nx = full_nx_s;
    assign ready   = ready_r;

endmodule

// File: rtl/parallel2serial.sv
// Parallel-to-serial transmitter: framed words of DATA_W data bits plus PAD_BITS filler,
// with a one-entry hold register for gapless back-to-back streaming.
module parallel2serial
    import p2s_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int PAD_BITS  = DEF_PAD_BITS,
    parameter int MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic              clk,
    input  logic              rst_n,
    parallel2serial_if.slave  bus
);

    localparam int CNT_W = cnt_width(DATA_W, PAD_BITS);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DATA_W + PAD_BITS - 1);

    p2s_state_e        state_r, state_nx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nx_s;
    logic [DATA_W-1:0] shift_r, shift_nx_s;
    logic [DATA_W-1:0] hold_dout_s;
    logic              hold_full_s, hold_full_nx_s, hold_ready_s;
    logic              push_s, pop_s, accept_s, frame_end_s;
    logic              dout_serial_r, dout_valid_r, dout_last_r, busy_r;
    logic              dout_serial_nx_s, dout_valid_nx_s, dout_last_nx_s, busy_nx_s;

    function automatic logic cur_bit(input logic [DATA_W-1:0] word);
        return (MSB_FIRST != 0) ? word[DATA_W-1] : word[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] word);
        return (MSB_FIRST != 0) ? {word[DATA_W-2:0], 1'b0} : {1'b0, word[DATA_W-1:1]};
    endfunction

    p2s_hold_buf #(.DATA_W(DATA_W)) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_s),
        .pop     (pop_s),
        .din     (bus.din_parallel),
        .dout    (hold_dout_s),
        .full    (hold_full_s),
        .full_nx (hold_full_nx_s),
        .ready   (hold_ready_s)
    );

    assign accept_s    = bus.din_valid && hold_ready_s;
    // With no filler the last data slot is also the frame's last slot.
    assign frame_end_s = (PAD_BITS == 0) ? ((state_r == SHIFT) && (cnt_r == LAST_DATA))
                                         : ((state_r == PAD)   && (cnt_r == LAST_SLOT));

    // State, slot counter and shifter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            shift_r <= '0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            shift_r <= shift_nx_s;
        end
    end

    // Next-state, counter, shifter and hold push/pop decisions.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        shift_nx_s = shift_r;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nx_s = '0;
                if (accept_s) begin
                    state_nx_s = SHIFT;
                    shift_nx_s = bus.din_parallel;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT, PAD: begin
                if (frame_end_s) begin
                    cnt_nx_s = '0;
                    if (hold_full_s) begin
                        state_nx_s = SHIFT;
                        shift_nx_s = hold_dout_s;
                        pop_s      = 1'b1;
                    end else if (accept_s) begin
                        state_nx_s = SHIFT;
                        shift_nx_s = bus.din_parallel;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end else begin
                    cnt_nx_s   = cnt_r + CNT_W'(1);
                    shift_nx_s = advance(shift_r);
                    push_s     = accept_s;
                    if ((state_r == SHIFT) && (cnt_r == LAST_DATA)) begin
                        state_nx_s = PAD;
                    end else begin
                        state_nx_s = state_r;
                    end
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // Output values for the slot entered at the next edge.
    always_comb begin
        dout_valid_nx_s  = (state_nx_s != IDLE);
        dout_serial_nx_s = 1'b0;
        dout_last_nx_s   = 1'b0;
        if (state_nx_s == SHIFT) begin
            dout_serial_nx_s = cur_bit(shift_nx_s);
            dout_last_nx_s   = (cnt_nx_s == LAST_DATA);
        end else begin
            dout_serial_nx_s = 1'b0;
            dout_last_nx_s   = 1'b0;
        end
        busy_nx_s = (state_nx_s != IDLE) || hold_full_nx_s;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_serial_r <= 1'b0;
            dout_valid_r  <= 1'b0;
            dout_last_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            dout_serial_r <= dout_serial_nx_s;
            dout_valid_r  <= dout_valid_nx_s;
            dout_last_r   <= dout_last_nx_s;
            busy_r        <= busy_nx_s;
        end
    end

    assign bus.din_ready   = hold_ready_s;
    assign bus.dout_serial = dout_serial_r;
    assign bus.dout_valid  = dout_valid_r;
    assign bus.dout_last   = dout_last_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_parallel2serial.sv
// Directed bench: default instance (8 data, 1 pad, MSB first) and a no-pad LSB-first instance.
module tb_parallel2serial;

    typedef struct {
        logic       rst_n;
        logic [7:0] din;
        logic       valid;
        logic       e_serial;
        logic       e_valid;
        logic       e_last;
        logic       e_ready;
        logic       e_busy;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    bit   sel;
    bit   seen_not_ready;
    logic [2:0] log_q[$];
    logic       exp_q[$];
    logic [7:0] rx_q[$];

    parallel2serial_if #(.DATA_W(8)) ifa ();
    parallel2serial_if #(.DATA_W(8)) ifb ();

    parallel2serial #(.DATA_W(8), .PAD_BITS(1), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    parallel2serial #(.DATA_W(8), .PAD_BITS(0), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        if (sel) begin
            ifb.din_valid = v;
            ifb.din_parallel = d;
        end else begin
            ifa.din_valid = v;
            ifa.din_parallel = d;
        end
    endtask

    function automatic logic cur_ready();
        return sel ? ifb.din_ready : ifa.din_ready;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (sel) log_q.push_back({ifb.dout_valid, ifb.dout_serial, ifb.dout_last});
        else     log_q.push_back({ifa.dout_valid, ifa.dout_serial, ifa.dout_last});
    endtask

    // Present a word and step until the edge that transfers it; leaves din_valid high.
    task automatic send_word(input logic [7:0] d);
        bit ok;
        logic r;
        ok = 1'b0;
        drive(1'b1, d);
        for (int t = 0; t < 40 && !ok; t++) begin
            r = cur_ready();
            if (!r) seen_not_ready = 1'b1;
            step();
            ok = r;
        end
        if (!ok) chk($sformatf("send %02h timeout", d), 32'd0, 32'd1);
    endtask

    task automatic add_word(input logic [7:0] d, input bit msb, input int pad);
        for (int i = 0; i < 8; i++) exp_q.push_back(msb ? d[7-i] : d[i]);
        for (int i = 0; i < pad; i++) exp_q.push_back(1'b0);
    endtask

    // Stream must be nslots contiguous valid slots matching exp_q, followed by idle.
    task automatic check_stream(input string name, input int nslots, input int flen);
        int f;
        logic [2:0] e;
        f = -1;
        for (int i = 0; i < log_q.size(); i++) if (f < 0 && log_q[i][2]) f = i;
        if (f < 0) begin
            chk({name, " start"}, 32'd0, 32'd1);
        end else begin
            for (int k = 0; k <= nslots; k++) begin
                e = (f + k < log_q.size()) ? log_q[f+k] : 3'b000;
                if (k == nslots) begin
                    chk($sformatf("%s idle after", name), {31'd0, e[2]}, 32'd0);
                end else begin
                    chk($sformatf("%s slot%0d valid", name, k), {31'd0, e[2]}, 32'd1);
                    chk($sformatf("%s slot%0d bit", name, k), {31'd0, e[1]}, {31'd0, exp_q[k]});
                    chk($sformatf("%s slot%0d last", name, k), {31'd0, e[0]},
                        {31'd0, ((k % flen) == 7)});
                end
            end
        end
    endtask

    vec_t vec[12];

    initial begin
        logic [7:0] a5;
        logic [7:0] sr;
        logic       r;
        bit         got;
        int         cnt;
        int         nvalid;
        n_tests = 0;
        n_fail = 0;
        sel = 1'b0;
        seen_not_ready = 1'b0;
        rst_n = 1'b0;
        ifa.din_valid = 1'b0; ifa.din_parallel = 8'h00;
        ifb.din_valid = 1'b0; ifb.din_parallel = 8'h00;

        a5 = 8'hA5;
        vec[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 1; k <= 8; k++)
            vec[k] = '{1'b1, (k == 1) ? 8'hA5 : 8'h00, (k == 1), a5[8-k], 1'b1, (k == 8), 1'b1, 1'b1};
        vec[9]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vec[10] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[11] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset and single word A5 with its filler slot.
        for (int i = 0; i < 12; i++) begin
            rst_n = vec[i].rst_n;
            drive(vec[i].valid, vec[i].din);
            step();
            chk($sformatf("v%0d serial", i), {31'd0, ifa.dout_serial}, {31'd0, vec[i].e_serial});
            chk($sformatf("v%0d valid", i),  {31'd0, ifa.dout_valid},  {31'd0, vec[i].e_valid});
            chk($sformatf("v%0d last", i),   {31'd0, ifa.dout_last},   {31'd0, vec[i].e_last});
            chk($sformatf("v%0d ready", i),  {31'd0, ifa.din_ready},   {31'd0, vec[i].e_ready});
            chk($sformatf("v%0d busy", i),   {31'd0, ifa.busy},        {31'd0, vec[i].e_busy});
        end
        chk("b reset busy", {31'd0, ifb.busy}, 32'd0);

        // Back-to-back 3C, FF, 01: 27 contiguous slots, ready drops while hold is full.
        log_q.delete(); exp_q.delete(); seen_not_ready = 1'b0;
        send_word(8'h3C); send_word(8'hFF); send_word(8'h01);
        drive(1'b0, 8'h00);
        repeat (30) step();
        add_word(8'h3C, 1'b1, 1); add_word(8'hFF, 1'b1, 1); add_word(8'h01, 1'b1, 1);
        check_stream("b2b", 27, 9);
        chk("b2b ready dropped", {31'd0, seen_not_ready}, 32'd1);
        chk("b2b busy end", {31'd0, ifa.busy}, 32'd0);

        // Loopback through a count-to-frame-then-wrap deserializer model.
        log_q.delete(); rx_q.delete();
        send_word(8'h00); send_word(8'h80); send_word(8'h7E);
        drive(1'b0, 8'h00);
        repeat (30) step();
        cnt = 0; sr = 8'h00;
        foreach (log_q[i]) begin
            if (log_q[i][2]) begin
                if (cnt < 8) sr = {sr[6:0], log_q[i][1]};
                if (cnt == 7) rx_q.push_back(sr);
                cnt = (cnt == 8) ? 0 : cnt + 1;
            end
        end
        chk("loop count", rx_q.size(), 32'd3);
        if (rx_q.size() == 3) begin
            chk("loop w0", {24'd0, rx_q[0]}, 32'h00);
            chk("loop w1", {24'd0, rx_q[1]}, 32'h80);
            chk("loop w2", {24'd0, rx_q[2]}, 32'h7E);
        end

        // Reset on the 4th bit of C3 with 55 held: both words discarded.
        send_word(8'hC3);
        drive(1'b1, 8'h55);
        repeat (3) step();
        chk("pre-rst 4th bit", {31'd0, ifa.dout_serial}, 32'd0);
        chk("pre-rst busy", {31'd0, ifa.busy}, 32'd1);
        rst_n = 1'b0;
        step();
        chk("rst serial", {31'd0, ifa.dout_serial}, 32'd0);
        chk("rst valid", {31'd0, ifa.dout_valid}, 32'd0);
        chk("rst last", {31'd0, ifa.dout_last}, 32'd0);
        chk("rst ready", {31'd0, ifa.din_ready}, 32'd1);
        chk("rst busy", {31'd0, ifa.busy}, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 8'h00);
        log_q.delete();
        repeat (20) step();
        nvalid = 0;
        foreach (log_q[i]) nvalid += int'(log_q[i][2]);
        chk("post-rst valid cycles", nvalid, 32'd0);

        // No-pad LSB-first instance: 01 then 80 stream with no gap.
        sel = 1'b1;
        log_q.delete(); exp_q.delete();
        send_word(8'h01); send_word(8'h80);
        drive(1'b0, 8'h00);
        repeat (20) step();
        add_word(8'h01, 1'b0, 0); add_word(8'h80, 1'b0, 0);
        check_stream("lsb", 16, 8);

        // Word offered exactly while dout_last is high with hold empty.
        log_q.delete(); exp_q.delete();
        send_word(8'hA5);
        drive(1'b0, 8'h00);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            step();
            got = ifb.dout_last;
        end
        chk("last seen", {31'd0, got}, 32'd1);
        r = ifb.din_ready;
        chk("ready at last", {31'd0, r}, 32'd1);
        drive(1'b1, 8'h3C);
        step();
        chk("ready after load", {31'd0, ifb.din_ready}, 32'd1);
        drive(1'b0, 8'h00);
        repeat (20) step();
        add_word(8'hA5, 1'b0, 0); add_word(8'h3C, 1'b0, 0);
        check_stream("onlast", 16, 8);
        chk("b busy end", {31'd0, ifb.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
